dense_layer_mac: RTL and testbench

//  Parametrised fully-connected NN layer: N_OUT neurons each compute
//  act(sum_i w[o][i]*x[i] + b[o]) in signed fixed point (FRAC_W fraction bits).

---
 rtl/dense_layer_mac.sv | 161 ++++++++++++++++
 tb/tb_dense_layer_mac.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dense_layer_mac.sv
// Fully-connected layer: N_OUT parallel MACs over a streamed input vector,
// then bias, floor-shift, saturation and optional ReLU into one packed result.
module dense_layer_mac #(
  parameter int N_IN     = 2,
  parameter int N_OUT    = 2,
  parameter int DATA_W   = 8,
  parameter int FRAC_W   = 4,
  parameter int ACT_MODE = 1,
  localparam int CFG_AW  = $clog2(N_OUT*(N_IN+1))
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_we,
  input  logic [CFG_AW-1:0]       cfg_addr,
  input  logic [DATA_W-1:0]       cfg_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic                    busy
);

  localparam int ACC_W = 2*DATA_W + $clog2(N_IN) + 1;
  localparam int SUM_W = ACC_W + 1;
  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic signed [DATA_W-1:0] ONE     = DATA_W'(1 << FRAC_W);
  localparam logic signed [SUM_W-1:0]  SAT_MAX = (SUM_W'(1) <<< (DATA_W-1)) - SUM_W'(1);
  localparam logic signed [SUM_W-1:0]  SAT_MIN = -SAT_MAX - SUM_W'(1);

  typedef enum logic [1:0] {IDLE, ACC, FIN, OUT} state_t;

  state_t                    state_reg;
  logic [IDX_W-1:0]          in_idx_reg;
  logic                      in_ready_reg;
  logic                      out_valid_reg;
  logic                      busy_reg;
  logic signed [DATA_W-1:0]  w_reg [N_OUT][N_IN];
  logic signed [DATA_W-1:0]  b_reg [N_OUT];
  logic signed [ACC_W-1:0]   acc_reg [N_OUT];
  logic signed [DATA_W-1:0]  res_reg [N_OUT];
  logic signed [2*DATA_W-1:0] prod [N_OUT];
  logic signed [DATA_W-1:0]  act_val [N_OUT];

  logic accept;
  logic last_sample;
  logic cfg_ok;

  assign accept      = in_valid & in_ready_reg;
  assign last_sample = (in_idx_reg == IDX_W'(N_IN-1));
  assign cfg_ok      = cfg_we && (state_reg == IDLE) && (in_idx_reg == '0);

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;

  // Per-neuron datapath: product for the current sample and the finished output value.
  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_neuron
    logic signed [SUM_W-1:0]  sum_w;
    logic signed [SUM_W-1:0]  z_w;
    logic signed [DATA_W-1:0] sat_w;

    assign prod[gi] = w_reg[gi][in_idx_reg] * $signed(in_data);
    assign sum_w    = SUM_W'(acc_reg[gi]) + (SUM_W'(b_reg[gi]) <<< FRAC_W);
    assign z_w      = sum_w >>> FRAC_W;

    always_comb begin
      sat_w = z_w[DATA_W-1:0];
      if (z_w > SAT_MAX)
        sat_w = {1'b0, {(DATA_W-1){1'b1}}};
      else if (z_w < SAT_MIN)
        sat_w = {1'b1, {(DATA_W-1){1'b0}}};
    end

    assign act_val[gi] = (ACT_MODE == 1 && sat_w[DATA_W-1]) ? '0 : sat_w;
    assign out_data[gi*DATA_W +: DATA_W] = res_reg[gi];
  end

  // Coefficient store; weights then biases share one flat address space.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < N_OUT; o++) begin
        b_reg[o] <= ONE;
        for (int i = 0; i < N_IN; i++)
          w_reg[o][i] <= ONE;
      end
    end else if (cfg_ok) begin
      for (int o = 0; o < N_OUT; o++) begin
        if (cfg_addr == CFG_AW'(N_OUT*N_IN + o))
          b_reg[o] <= $signed(cfg_data);
        for (int i = 0; i < N_IN; i++)
          if (cfg_addr == CFG_AW'(o*N_IN + i))
            w_reg[o][i] <= $signed(cfg_data);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < N_OUT; o++) begin
        acc_reg[o] <= '0;
        res_reg[o] <= '0;
      end
    end else begin
      for (int o = 0; o < N_OUT; o++) begin
        if (accept)
          acc_reg[o] <= (state_reg == IDLE) ? ACC_W'(prod[o])
                                            : acc_reg[o] + ACC_W'(prod[o]);
        if (state_reg == FIN)
          res_reg[o] <= act_val[o];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      in_idx_reg    <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, ACC: begin
          if (accept) begin
            busy_reg <= 1'b1;
            if (last_sample) begin
              state_reg    <= FIN;
              in_ready_reg <= 1'b0;
            end else begin
              state_reg  <= ACC;
              in_idx_reg <= in_idx_reg + IDX_W'(1);
            end
          end
        end
        FIN: begin
          state_reg     <= OUT;
          out_valid_reg <= 1'b1;
        end
        OUT: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            in_idx_reg    <= '0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
          end
        end
        default: begin
          state_reg     <= IDLE;
          in_idx_reg    <= '0;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dense_layer_mac.sv
// Randomized bench for dense_layer_mac: a ReLU and an identity instance share stimulus
// and are compared against a plain-arithmetic model of the layer.
module tb_dense_layer_mac;

  localparam int N_IN  = 2;
  localparam int N_OUT = 2;
  localparam int DW    = 8;
  localparam int FW    = 4;
  localparam int CAW   = 3;
  localparam int NCOEF = N_OUT*(N_IN+1);

  logic clk = 1'b0;
  logic rst;
  logic cfg_we;
  logic [CAW-1:0] cfg_addr;
  logic [DW-1:0] cfg_data;
  logic in_valid;
  logic [DW-1:0] in_data;
  logic out_ready;

  logic in_ready_r, out_valid_r, busy_r;
  logic in_ready_i, out_valid_i, busy_i;
  logic [N_OUT*DW-1:0] out_data_r, out_data_i;

  int checks = 0;
  int failures = 0;
  int w_m [N_OUT][N_IN];
  int b_m [N_OUT];

  always #5 clk = ~clk;

  dense_layer_mac #(.N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DW), .FRAC_W(FW), .ACT_MODE(1)) dut_relu (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .in_valid(in_valid), .in_ready(in_ready_r), .in_data(in_data),
    .out_valid(out_valid_r), .out_ready(out_ready), .out_data(out_data_r), .busy(busy_r));

  dense_layer_mac #(.N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DW), .FRAC_W(FW), .ACT_MODE(0)) dut_ident (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .in_valid(in_valid), .in_ready(in_ready_i), .in_data(in_data),
    .out_valid(out_valid_i), .out_ready(out_ready), .out_data(out_data_i), .busy(busy_i));

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference neuron: exact integer dot product, floor division by 2^FW, clamp, activation.
  function automatic int model_out(input int o, input int x0, input int x1, input bit relu);
    longint s;
    longint z;
    s = longint'(w_m[o][0]) * x0 + longint'(w_m[o][1]) * x1 + longint'(b_m[o]) * (1 << FW);
    z = s >>> FW;
    if (z > 127) z = 127;
    if (z < -128) z = -128;
    if (relu && z < 0) z = 0;
    return int'(z);
  endfunction

  task automatic model_reset();
    for (int o = 0; o < N_OUT; o++) begin
      b_m[o] = 1 << FW;
      for (int i = 0; i < N_IN; i++) w_m[o][i] = 1 << FW;
    end
  endtask

  task automatic model_cfg(input int addr, input int data);
    if (addr < N_OUT*N_IN) w_m[addr / N_IN][addr % N_IN] = data;
    else if (addr < NCOEF) b_m[addr - N_OUT*N_IN] = data;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b0;
    cfg_addr = '0; cfg_data = '0; in_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic cfg_write(input int addr, input int data);
    cfg_we = 1'b1; cfg_addr = CAW'(addr); cfg_data = DW'(data);
    @(negedge clk);
    cfg_we = 1'b0;
    model_cfg(addr, data);
  endtask

  task automatic send_vector(input string tag, input int x0, input int x1, input int gap,
                             input int hold, input bit busy_cfg, input bit same_cfg);
    int xs [N_IN];
    int exp_r [N_OUT];
    int exp_i [N_OUT];
    int new_w;
    logic [N_OUT*DW-1:0] snap_r, snap_i;
    xs[0] = x0; xs[1] = x1;
    for (int o = 0; o < N_OUT; o++) begin
      exp_r[o] = model_out(o, x0, x1, 1'b1);
      exp_i[o] = model_out(o, x0, x1, 1'b0);
    end
    new_w = int'($urandom_range(0, 255)) - 128;
    for (int i = 0; i < N_IN; i++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      check({tag, "_in_ready"}, longint'(in_ready_r), 1);
      in_valid = 1'b1;
      in_data = DW'(xs[i]);
      if (same_cfg && i == 0) begin
        cfg_we = 1'b1; cfg_addr = '0; cfg_data = DW'(new_w);
      end
      @(negedge clk);
      cfg_we = 1'b0;
    end
    if (same_cfg) model_cfg(0, new_w);
    // Keep offering junk data while the layer is finishing; it must not be taken.
    in_data = DW'($urandom_range(0, 255));
    check({tag, "_fin_valid"}, longint'(out_valid_r), 0);
    check({tag, "_fin_ready"}, longint'(in_ready_r), 0);
    @(negedge clk);
    check({tag, "_lat_valid"}, longint'(out_valid_r), 1);
    check({tag, "_lat_valid_id"}, longint'(out_valid_i), 1);
    for (int o = 0; o < N_OUT; o++) begin
      check($sformatf("%s_n%0d_relu", tag, o), longint'($signed(out_data_r[o*DW +: DW])), exp_r[o]);
      check($sformatf("%s_n%0d_ident", tag, o), longint'($signed(out_data_i[o*DW +: DW])), exp_i[o]);
    end
    snap_r = out_data_r;
    snap_i = out_data_i;
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      if (busy_cfg) begin
        cfg_we = 1'b1;
        cfg_addr = CAW'($urandom_range(0, NCOEF-1));
        cfg_data = DW'($urandom_range(0, 255));
      end
      @(negedge clk);
      cfg_we = 1'b0;
      check({tag, "_hold_valid"}, longint'(out_valid_r), 1);
      check({tag, "_hold_data"}, longint'(out_data_r), longint'(snap_r));
      check({tag, "_hold_data_id"}, longint'(out_data_i), longint'(snap_i));
      check({tag, "_hold_ready"}, longint'(in_ready_r), 0);
      check({tag, "_hold_busy"}, longint'(busy_r), 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    check({tag, "_done_valid"}, longint'(out_valid_r), 0);
    check({tag, "_done_busy"}, longint'(busy_r), 0);
    check({tag, "_done_ready"}, longint'(in_ready_r), 1);
    $display("vector %s x=(%0d,%0d) relu=(%0d,%0d) ident=(%0d,%0d)", tag, x0, x1,
             exp_r[0], exp_r[1], exp_i[0], exp_i[1]);
  endtask

  initial begin
    do_reset();
    check("rst_in_ready", longint'(in_ready_r), 1);
    check("rst_busy", longint'(busy_r), 0);
    check("rst_out_valid", longint'(out_valid_r), 0);
    check("rst_out_data", longint'(out_data_r), 0);

    // Default coefficients: 1.0*1.0 + 1.0*1.0 + 1.0 = 3.0
    check("t1_model", longint'(model_out(0, 16, 16, 1'b1)), 48);
    send_vector("t1", 16, 16, 0, 0, 1'b0, 1'b0);

    cfg_write(0, -32);
    cfg_write(1, 16);
    cfg_write(4, 0);
    check("t2_model", longint'(model_out(0, 16, 16, 1'b0)), -16);
    send_vector("t2", 16, 16, 0, 0, 1'b0, 1'b0);

    for (int a = 0; a < NCOEF; a++) cfg_write(a, 127);
    send_vector("t3_pos", 127, 127, 0, 0, 1'b0, 1'b0);
    for (int a = 0; a < NCOEF; a++) cfg_write(a, -128);
    send_vector("t3_neg", 127, 127, 0, 0, 1'b0, 1'b0);

    do_reset();
    send_vector("t4", 16, 16, 0, 5, 1'b0, 1'b0);

    cfg_write(2, 50);
    in_valid = 1'b1; in_data = DW'(100);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("t5_busy", longint'(busy_r), 0);
    check("t5_ready", longint'(in_ready_r), 1);
    send_vector("t5", 16, 16, 0, 0, 1'b0, 1'b0);

    send_vector("t6_busycfg", 16, 16, 0, 4, 1'b1, 1'b0);
    send_vector("t6_gaps", 16, 16, 3, 0, 1'b0, 1'b0);
    cfg_write(7, 99);
    send_vector("t6_oob", 16, 16, 0, 0, 1'b0, 1'b0);
    send_vector("same_cfg", 20, -7, 0, 0, 1'b0, 1'b1);

    for (int n = 0; n < 25; n++) begin
      cfg_write(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)) - 128);
      cfg_write(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)) - 128);
      send_vector($sformatf("rnd%0d", n),
                  int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                  int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
